frame_receiver: RTL and testbench
=================================

FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 SHALL have parameter: width, 8, data bits per frame.
REQ-002 SHALL have parameter: depth, 4, output FIFO entries (power of two, minimum 2).
REQ-003 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port: sample_en  input  1  single-cycle pulse; sample serial_in this cycle.
REQ-006 SHALL have port: serial_in  input  1  serial bit stream, MSB first (the shift-register serial output).
REQ-007 SHALL have port: frame_start  input  1  single-cycle pulse; begin new frame, abort any partial one.
REQ-008 SHALL have port: data_out  output  width  FIFO head word.
REQ-009 SHALL have port: data_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port: data_ready  input  1  consumer accepts head when data_valid high.
REQ-011 SHALL have port: full  output  1  FIFO holds depth words.
REQ-012 SHALL have port: overflow  output  1  sticky; a completed word was dropped because the FIFO was full.
REQ-013 SHALL have port: parity_err  output  1  single-cycle pulse on parity mismatch (see REQ-030).

Function
REQ-014 SHALL implement states IDLE, SHIFT, PARITY; PARITY reachable only when parity is compiled in.
REQ-015 SHALL ignore sample_en in IDLE.
REQ-016 SHALL, on frame_start in any state, clear the bit counter and shift register and enter SHIFT.
REQ-017 SHALL, when frame_start and sample_en coincide, give frame_start priority and discard that sample.
REQ-018 SHALL, in SHIFT on each sample_en, shift serial_in into the LSB (left shift) and increment the bit counter.
REQ-019 SHALL, on the width-th sample, push the assembled word into the FIFO (parity off) and return to IDLE.
REQ-020 SHALL assert data_valid with the new word on data_out on the cycle after the final sample_en; latency 1 cycle.
REQ-021 SHALL pop the head when data_valid and data_ready are both high at a clock edge; data_out is don't-care when data_valid is low.
REQ-022 SHALL, when a push hits a full FIFO with no simultaneous pop, drop the word, leave FIFO contents unchanged and set overflow.
REQ-023 SHALL, when push and pop coincide at full, perform both; no overflow.
REQ-024 SHALL, when push and pop coincide at empty, accept the push; data_valid rises next cycle.
REQ-025 SHALL wrap FIFO read/write pointers modulo depth and preserve word order.
REQ-026 SHALL hold overflow high until reset.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, counter 0, shift register 0, FIFO empty.
REQ-028 SHALL drive data_valid 0, full 0, overflow 0, parity_err 0, data_out 0 during reset.
REQ-029 SHALL discard any partial frame when reset asserts mid-frame; no word is pushed.

Configuration
REQ-030 SHALL, with FRAME_RECEIVER_PARITY_EN defined, enter PARITY after the width-th bit, take one more sample as the even-parity bit over data plus parity, push the word only if parity matches, else drop it and pulse parity_err for one cycle.
REQ-031 SHALL, without FRAME_RECEIVER_PARITY_EN, omit PARITY, push after the width-th bit, and tie parity_err to 0; port list unchanged.

Structure
REQ-032 SHALL take the state enum, default width/depth constants and pointer-width function from shared package frame_receiver_pkg.
REQ-033 SHALL implement the FIFO as sub-module frame_fifo (push/pop/full/empty, parameters width and depth).

Verification
REQ-034 SHALL cover: frame_start, then 8 samples 1,0,1,0,0,1,0,1 -> data_out 8'hA5, data_valid 1 cycle after 8th sample.
REQ-035 SHALL cover: 5 frames 8'h01..8'h05 with data_ready 0 -> full 1 after 4th, 8'h05 dropped, overflow 1; drain gives 01,02,03,04.
REQ-036 SHALL cover: frame_start, 3 bits, frame_start, 8 bits of 8'h3C -> exactly one word 8'h3C.
REQ-037 SHALL cover: rst_n low after 5 bits -> all outputs 0 at once, no word after release; next full frame 8'hFF -> 8'hFF.
REQ-038 SHALL cover: FIFO full, data_ready 1 on the final sample of 8'h77 -> pop and push same edge, full stays 1, overflow 0.
REQ-039 SHALL cover, with FRAME_RECEIVER_PARITY_EN: 8'hA5 plus parity 0 -> accepted; 8'hA5 plus parity 1 -> parity_err pulse, FIFO unchanged.

Source files
------------

// File: rtl/frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM states, default sizes
// and the pointer-width helper used by the receiver and its output FIFO.
package frame_receiver_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_e;

  // Index width for a structure of n entries; never below one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Output FIFO of the frame receiver: power-of-two depth, first-word-fall-through
// head, push accepted at full only when a pop happens on the same edge.
module frame_fifo
  import frame_receiver_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int depth = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [width-1:0] i_data,
  input  logic             i_pop,
  output logic [width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int PW = ptr_w(depth);

  logic [width-1:0] r_mem [depth];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PW+1)'(depth));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && o_full && !w_pop;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; o_data is masked while empty, so stale
  // contents are never observable and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/frame_receiver.sv
// Serial-to-parallel frame receiver (MSB first) feeding an output FIFO.
// Define FRAME_RECEIVER_PARITY_EN to require a trailing even-parity bit per frame.
module frame_receiver
  import frame_receiver_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int depth = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             serial_in,
  input  logic             frame_start,
  output logic [width-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             full,
  output logic             overflow,
  output logic             parity_err
);

  localparam int CW = ptr_w(width);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [width-1:0] r_shift;
  logic             r_overflow;

  logic             w_sample;
  logic             w_last_bit;
  logic [width-1:0] w_word_next;
  logic             w_push;
  logic [width-1:0] w_push_data;
  logic             w_empty;
  logic             w_drop;

  assign w_sample    = sample_en && !frame_start;
  assign w_last_bit  = (r_state == S_SHIFT) && w_sample && (r_cnt == CW'(width - 1));
  assign w_word_next = {r_shift[width-2:0], serial_in};

`ifdef FRAME_RECEIVER_PARITY_EN
  localparam state_e AFTER_DATA = S_PARITY;

  logic w_par_done;
  logic w_par_ok;
  logic r_parity_err;

  // Even parity: data bits plus the parity bit must hold an even number of ones.
  assign w_par_done  = (r_state == S_PARITY) && w_sample;
  assign w_par_ok    = ~^{r_shift, serial_in};
  assign w_push      = w_par_done && w_par_ok;
  assign w_push_data = r_shift;
  assign parity_err  = r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= w_par_done && !w_par_ok;
  end
`else
  localparam state_e AFTER_DATA = S_IDLE;

  logic w_unused_msb;

  // The word is pushed straight from the shifter input, so its top bit is never read back.
  assign w_unused_msb = r_shift[width-1];
  assign w_push       = w_last_bit;
  assign w_push_data  = w_word_next;
  assign parity_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (frame_start) begin
      r_state <= S_SHIFT;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (sample_en) begin
            r_shift <= w_word_next;
            if (w_last_bit) begin
              r_cnt   <= '0;
              r_state <= AFTER_DATA;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_PARITY: if (sample_en) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overflow <= 1'b0;
    else        r_overflow <= r_overflow | w_drop;
  end

  frame_fifo #(
    .width (width),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (data_ready),
    .o_data  (data_out),
    .o_full  (full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign data_valid = !w_empty;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_frame_receiver.sv
// Self-checking bench for frame_receiver: directed scenarios plus randomized
// frames, compared every cycle against a queue-based reference model.
module tb_frame_receiver;

  localparam int W = 8;
  localparam int D = 4;
`ifdef FRAME_RECEIVER_PARITY_EN
  localparam int FRAME_BITS = W + 1;
`else
  localparam int FRAME_BITS = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_en = 1'b0;
  logic         serial_in = 1'b0;
  logic         frame_start = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         full;
  logic         overflow;
  logic         parity_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] m_q[$];
  bit           m_bits[$];
  bit           m_active = 0;
  bit           m_ovf = 0;
  bit           m_perr = 0;

  frame_receiver #(.width(W), .depth(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .serial_in   (serial_in),
    .frame_start (frame_start),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .full        (full),
    .overflow    (overflow),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame rules applied at one rising edge: abort/restart, collect bits, then
  // pop before push so a full FIFO with a pop still accepts the new word.
  task automatic model_edge(input logic fs, input logic se, input logic sin, input logic rdy);
    bit           pop;
    bit           have;
    int           ones;
    logic [W-1:0] w;
    pop    = (m_q.size() > 0) && rdy;
    have   = 0;
    m_perr = 0;
    w      = '0;
    if (fs) begin
      m_active = 1;
      m_bits.delete();
    end else if (se && m_active) begin
      m_bits.push_back(sin);
      if (m_bits.size() == FRAME_BITS) begin
        ones = 0;
        for (int i = 0; i < FRAME_BITS; i++) ones += int'(m_bits[i]);
        for (int i = 0; i < W; i++) w = {w[W-2:0], m_bits[i]};
        if (FRAME_BITS == W || (ones % 2) == 0) have = 1;
        else m_perr = 1;
        m_active = 0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (have) begin
      if (m_q.size() < D) m_q.push_back(w);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_outputs();
    check("data_valid", data_valid, m_q.size() != 0);
    check("full", full, m_q.size() == D);
    check("overflow", overflow, m_ovf);
    check("parity_err", parity_err, m_perr);
    if (m_q.size() != 0) check("data_out", data_out, m_q[0]);
  endtask

  task automatic cycle(input logic fs, input logic se, input logic sin, input logic rdy);
    frame_start = fs;
    sample_en   = se;
    serial_in   = sin;
    data_ready  = rdy;
    @(posedge clk);
    model_edge(fs, se, sin, rdy);
    #1;
    frame_start = 1'b0;
    sample_en   = 1'b0;
    compare_outputs();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input bit flip, input bit rdy_body,
                           input bit rdy_last, input int gap_max);
    logic b;
    for (int i = 0; i < FRAME_BITS; i++) begin
      b = (i < W) ? w[W-1-i] : ((^w) ^ flip);
      repeat ($urandom_range(gap_max)) cycle(1'b0, 1'b0, 1'($urandom), rdy_body);
      cycle(1'b0, 1'b1, b, (i == FRAME_BITS - 1) ? rdy_last : rdy_body);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit flip, input bit rdy_body,
                            input bit rdy_last, input int gap_max);
    cycle(1'b1, 1'b0, 1'b0, rdy_body);
    send_bits(w, flip, rdy_body, rdy_last, gap_max);
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * D && m_q.size() > 0; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("drained", data_valid, 1'b0);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_data_out", data_out, '0);
    m_q.delete();
    m_bits.delete();
    m_active = 0;
    m_ovf    = 0;
    m_perr   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_now();

    // 0xA5 assembled MSB first, visible one cycle after the last sample
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0);
    check("a5_word", data_out, 8'hA5);
    drain();

    // five frames with no consumer: fifth is dropped, overflow sticks
    for (int i = 1; i <= 5; i++) send_frame(W'(i), 1'b0, 1'b0, 1'b0, 1);
    check("ovf_after_5", overflow, 1'b1);
    check("head_after_5", data_out, 8'h01);
    drain();

    // aborted frame, then a restart that coincides with a sample
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    send_bits(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    check("3c_word", data_out, 8'h3C);
    drain();

    // reset mid-frame discards the partial word
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    reset_now();
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 0);
    check("ff_word", data_out, 8'hFF);
    drain();

    // push and pop on the same edge while full
    for (int i = 0; i < D; i++) send_frame(W'(8'h10 + i), 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, 0);
    check("full_kept", full, 1'b1);
    check("no_overflow", overflow, 1'b0);
    drain();

`ifdef FRAME_RECEIVER_PARITY_EN
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0);
    check("par_ok_word", data_out, 8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    check("par_bad_pulse", parity_err, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("par_pulse_end", parity_err, 1'b0);
    drain();
`endif

    // randomized frames, consumers, gaps, aborts and parity faults
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(5) == 0) begin
        cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        repeat ($urandom_range(W - 1)) cycle(1'b0, 1'b1, 1'($urandom), 1'($urandom));
      end
      send_frame(W'($urandom), (FRAME_BITS > W) && ($urandom_range(3) == 0),
                 1'($urandom), 1'($urandom), 2);
      repeat ($urandom_range(3)) cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
